// File: rtl/xe1ap_host_rx_pkg.sv
// rtl/xe1ap_host_rx_pkg.sv - shared types, nybble map and frame decode for the XE-1AP host receiver
package xe1ap_pkg;

    localparam int NYBBLES = 12;

    localparam int IDX_BTN0 = 0;
    localparam int IDX_BTN1 = 1;
    localparam int IDX_Y_HI = 2;
    localparam int IDX_X_HI = 3;
    localparam int IDX_T_HI = 4;
    localparam int IDX_AUX0 = 5;
    localparam int IDX_Y_LO = 6;
    localparam int IDX_X_LO = 7;
    localparam int IDX_T_LO = 8;
    localparam int IDX_AUX1 = 9;
    localparam int IDX_BTN2 = 10;
    localparam int IDX_AUX2 = 11;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LOW,
        WAIT_EDGE,
        SAMPLE,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic [11:0] buttons;
        logic [7:0]  ch0;
        logic [7:0]  ch1;
        logic [7:0]  ch2;
    } frame_t;

    function automatic logic [3:0] frame_nyb(input logic [47:0] raw, input int k);
        return raw[4*k +: 4];
    endfunction

    // Pad sends buttons active-low; analog channels arrive as high nybble then low nybble.
    function automatic frame_t decode_frame(input logic [47:0] raw);
        frame_t f;
        f.buttons = {~frame_nyb(raw, IDX_BTN0), ~frame_nyb(raw, IDX_BTN1), ~frame_nyb(raw, IDX_BTN2)};
        f.ch0     = {frame_nyb(raw, IDX_Y_HI), frame_nyb(raw, IDX_Y_LO)};
        f.ch1     = {frame_nyb(raw, IDX_X_HI), frame_nyb(raw, IDX_X_LO)};
        f.ch2     = {frame_nyb(raw, IDX_T_HI), frame_nyb(raw, IDX_T_LO)};
        return f;
    endfunction

endpackage

// File: rtl/xe1ap_host_rx_if.sv
// rtl/xe1ap_host_rx_if.sv - pad-side lines between XE-1AP host receiver and pad
interface xe1ap_host_rx_if;
    logic       req;
    logic       trg1;
    logic       trg2;
    logic [3:0] data;

    modport master (output req, input trg1, input trg2, input data);
    modport slave  (input req, output trg1, output trg2, output data);
endinterface

// File: rtl/xe1ap_host_rx_usec_tick.sv
// rtl/xe1ap_host_rx_usec_tick.sv - restartable microsecond tick divider
module xe1ap_usec_tick #(
    parameter int CLKPERUSEC = 50
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLKPERUSEC > 1) ? $clog2(CLKPERUSEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKPERUSEC - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, zeroed whenever the controller changes state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/xe1ap_host_rx.sv
// rtl/xe1ap_host_rx.sv - XE-1AP host receiver top; optional trg1 phase check via XE1AP_RX_TRG1_CHECK_EN
module xe1ap_host_rx
    import xe1ap_pkg::*;
#(
    parameter int CLKPERUSEC      = 50,
    parameter int REQ_LOW_US      = 4,
    parameter int TIMEOUT_US      = 200,
    parameter int SAMPLE_DLY_CLKS = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  poll,
    xe1ap_host_rx_if.master       pad,
    output logic                  busy,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [47:0]           frame_raw,
    output logic [11:0]           buttons,
    output logic [7:0]            ch0,
    output logic [7:0]            ch1,
    output logic [7:0]            ch2
);
    localparam int US_MAX = (TIMEOUT_US > REQ_LOW_US) ? TIMEOUT_US : REQ_LOW_US;
    localparam int TW     = $clog2(US_MAX + 1);
    localparam int DW     = $clog2(SAMPLE_DLY_CLKS + 2);

    state_t        state, state_nxt;
    logic          trg2_s1, trg2_s2, trg2_prev;
    logic [3:0]    data_s1, data_s2;
    logic [TW-1:0] us_cnt;
    logic [DW-1:0] dly_cnt;
    logic [3:0]    idx;
    logic [47:0]   shadow;
    logic          tick, fall, phase_ok;

    xe1ap_usec_tick #(.CLKPERUSEC(CLKPERUSEC)) u_tick (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .restart (state_nxt != state),
        .tick    (tick)
    );

    // Two-flop synchronizers on the pad lines, plus trg2 history for fall detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            trg2_s1   <= 1'b1;
            trg2_s2   <= 1'b1;
            trg2_prev <= 1'b1;
            data_s1   <= 4'hF;
            data_s2   <= 4'hF;
        end else begin
            trg2_s1   <= pad.trg2;
            trg2_s2   <= trg2_s1;
            trg2_prev <= trg2_s2;
            data_s1   <= pad.data;
            data_s2   <= data_s1;
        end
    end

    assign fall = trg2_prev & ~trg2_s2;

`ifdef XE1AP_RX_TRG1_CHECK_EN
    logic trg1_s1, trg1_s2;

    // trg1 must toggle in step with the nybble index: low on even, high on odd.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            trg1_s1 <= 1'b1;
            trg1_s2 <= 1'b1;
        end else begin
            trg1_s1 <= pad.trg1;
            trg1_s2 <= trg1_s1;
        end
    end

    assign phase_ok = (trg1_s2 == idx[0]);
`else
    assign phase_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an edge in WAIT_EDGE takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (poll) state_nxt = REQ_LOW;
            REQ_LOW:   if (tick && us_cnt == TW'(REQ_LOW_US - 1)) state_nxt = WAIT_EDGE;
            WAIT_EDGE: begin
                if (fall) begin
                    state_nxt = SAMPLE;
                end else if (tick && us_cnt == TW'(TIMEOUT_US - 1)) begin
                    state_nxt = ERR;
                end
            end
            SAMPLE: begin
                if (dly_cnt == '0) begin
                    if (!phase_ok) begin
                        state_nxt = ERR;
                    end else if (idx == 4'(NYBBLES - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_EDGE;
                    end
                end
            end
            DONE:      state_nxt = IDLE;
            ERR:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: request line, counters, nybble capture and published frame.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_raw   <= '1;
            buttons     <= '0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            shadow      <= '1;
            idx         <= '0;
            us_cnt      <= '0;
            dly_cnt     <= '0;
            pad.req     <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (state_nxt != state) begin
                us_cnt <= '0;
            end else if (tick && (state == REQ_LOW || state == WAIT_EDGE)) begin
                us_cnt <= us_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (poll) begin
                        pad.req <= 1'b0;
                        busy    <= 1'b1;
                        idx     <= '0;
                    end
                end
                REQ_LOW: begin
                    if (state_nxt == WAIT_EDGE) pad.req <= 1'b1;
                end
                WAIT_EDGE: begin
                    if (state_nxt == SAMPLE) dly_cnt <= DW'(SAMPLE_DLY_CLKS);
                end
                SAMPLE: begin
                    if (dly_cnt != '0) begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end else if (phase_ok) begin
                        shadow[{idx, 2'b00} +: 4] <= data_s2;
                        if (idx != 4'(NYBBLES - 1)) idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    frame_raw                 <= shadow;
                    {buttons, ch0, ch1, ch2}  <= decode_frame(shadow);
                    frame_valid               <= 1'b1;
                    busy                      <= 1'b0;
                end
                ERR: begin
                    frame_err <= 1'b1;
                    pad.req   <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xe1ap_host_rx.sv
// tb/tb_xe1ap_host_rx.sv - randomized self-checking bench for xe1ap_host_rx
module tb_xe1ap_host_rx;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        poll    = 1'b0;
    logic        busy, frame_valid, frame_err;
    logic [47:0] frame_raw;
    logic [11:0] buttons;
    logic [7:0]  ch0, ch1, ch2;

    xe1ap_host_rx_if pad();

    xe1ap_host_rx dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .poll        (poll),
        .pad         (pad),
        .busy        (busy),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_raw   (frame_raw),
        .buttons     (buttons),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2)
    );

    always #10 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pad-line monitor: counts req pulses and frame pulses with timestamps.
    int   cyc = 0, req_falls = 0, valids = 0, errs = 0;
    int   t_fall = 0, t_rise = 0, t_err = 0;
    logic req_q = 1'b1;
    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (req_q && !pad.req) begin req_falls <= req_falls + 1; t_fall <= cyc; end
        if (!req_q && pad.req) t_rise <= cyc;
        if (frame_valid) valids <= valids + 1;
        if (frame_err) begin errs <= errs + 1; t_err <= cyc; end
        req_q <= pad.req;
    end

    // Reference model: nybble list in, expected published frame out.
    logic [3:0]  nyb [12];
    logic [47:0] exp_raw = '1;
    logic [11:0] exp_btn = '0;
    logic [7:0]  exp_c0 = '0, exp_c1 = '0, exp_c2 = '0;

    task automatic model_accept();
        for (int k = 0; k < 12; k++) exp_raw[4*k +: 4] = nyb[k];
        exp_btn = {~nyb[0], ~nyb[1], ~nyb[10]};
        exp_c0  = {nyb[2], nyb[6]};
        exp_c1  = {nyb[3], nyb[7]};
        exp_c2  = {nyb[4], nyb[8]};
    endtask

    task automatic model_reset();
        exp_raw = '1; exp_btn = '0; exp_c0 = '0; exp_c1 = '0; exp_c2 = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_raw"}, frame_raw, exp_raw);
        chk({tag, "_btn"}, buttons, exp_btn);
        chk({tag, "_ch0"}, ch0, exp_c0);
        chk({tag, "_ch1"}, ch1, exp_c1);
        chk({tag, "_ch2"}, ch2, exp_c2);
    endtask

    int v0, e0, r0;

    task automatic start_poll(input string tag, input bit dup);
        v0 = valids; e0 = errs; r0 = req_falls;
        @(posedge clk_sys); #1 poll = 1'b1;
        @(posedge clk_sys); #1 poll = 1'b0;
        @(negedge clk_sys);
        chk({tag, "_busy_hi"}, busy, 1);
        chk({tag, "_req_lo"}, pad.req, 0);
        if (dup) begin
            @(posedge clk_sys); #1 poll = 1'b1;
            @(posedge clk_sys); #1 poll = 1'b0;
        end
    endtask

    task automatic send_nybbles(input string tag, input int n, input bit trg1_zero, input bit dup);
        int w;
        w = 0;
        while (pad.req !== 1'b1 && w < 1000) begin @(negedge clk_sys); w++; end
        if (w >= 1000) chk({tag, "_req_release_timeout"}, 0, 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_sys); #1;
            pad.data = nyb[k];
            pad.trg1 = trg1_zero ? 1'b0 : k[0];
            repeat ($urandom_range(2, 5)) @(posedge clk_sys);
            #1 pad.trg2 = 1'b0;
            repeat (8) @(posedge clk_sys);
            #1 pad.trg2 = 1'b1;
            if (dup && k == 3) begin
                poll = 1'b1; @(posedge clk_sys); #1 poll = 1'b0;
            end
            repeat ($urandom_range(4, 8)) @(posedge clk_sys);
        end
    endtask

    task automatic wait_end(input string tag, output int dv, output int de, output int dr);
        int w;
        w = 0;
        while (valids == v0 && errs == e0 && w < 12000) begin @(negedge clk_sys); w++; end
        if (w >= 12000) chk({tag, "_end_timeout"}, 0, 1);
        @(negedge clk_sys);
        dv = valids - v0; de = errs - e0; dr = req_falls - r0;
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_req_hi"}, pad.req, 1);
    endtask

    task automatic good_frame(input string tag, input bit dup);
        int dv, de, dr;
        start_poll(tag, dup);
        send_nybbles(tag, 12, 1'b0, dup);
        wait_end(tag, dv, de, dr);
        model_accept();
        chk({tag, "_nvalid"}, dv, 1);
        chk({tag, "_nerr"}, de, 0);
        chk({tag, "_nreq"}, dr, 1);
        check_outputs(tag);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv, de, dr;
        pad.trg1 = 1'b1; pad.trg2 = 1'b1; pad.data = 4'hF;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_req", pad.req, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        check_outputs("rst");
        @(posedge clk_sys); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);

        // Directed frame: button 1 pressed in both button groups, Y=C0, X=00.
        nyb[0] = 4'h7; nyb[1] = 4'hF; nyb[2] = 4'hC; nyb[3] = 4'h0;
        nyb[4] = 4'h0; nyb[5] = 4'hF; nyb[6] = 4'h0; nyb[7] = 4'h0;
        nyb[8] = 4'h0; nyb[9] = 4'hF; nyb[10] = 4'h7; nyb[11] = 4'hF;
        good_frame("direct", 1'b0);
        chk("direct_b11", buttons[11], 1);
        chk("direct_b10", buttons[10], 0);
        chk("direct_b3", buttons[3], 1);
        chk("direct_y", ch0, 8'hC0);
        chk("direct_x", ch1, 8'h00);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
            good_frame($sformatf("rand%0d", f), 1'b0);
        end

        for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
        good_frame("dup", 1'b1);

        // No pad: trg2 stays high, expect timeout.
        start_poll("nopad", 1'b0);
        send_nybbles("nopad", 0, 1'b0, 1'b0);
        wait_end("nopad", dv, de, dr);
        chk("nopad_nerr", de, 1);
        chk("nopad_nvalid", dv, 0);
        chk("nopad_req_low_cycles", t_rise - t_fall, 200);
        chk("nopad_err_time_ok", ((t_err - t_fall) >= 10200) && ((t_err - t_fall) <= 10203), 1);
        check_outputs("nopad");

        // Pad stops after 7 nybbles.
        for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
        start_poll("short", 1'b0);
        send_nybbles("short", 7, 1'b0, 1'b0);
        wait_end("short", dv, de, dr);
        chk("short_nerr", de, 1);
        chk("short_nvalid", dv, 0);
        check_outputs("short");

        // Reset in the middle of a frame, after nybble 5.
        for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
        start_poll("midrst", 1'b0);
        send_nybbles("midrst", 6, 1'b0, 1'b0);
        @(posedge clk_sys); #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_req", pad.req, 1);
        chk("midrst_busy", busy, 0);
        check_outputs("midrst");
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
        good_frame("afterrst", 1'b0);

        // trg1 held low for the whole frame.
        for (int k = 0; k < 12; k++) nyb[k] = 4'($urandom_range(0, 15));
        start_poll("trg1", 1'b0);
        send_nybbles("trg1", 12, 1'b1, 1'b0);
        wait_end("trg1", dv, de, dr);
`ifdef XE1AP_RX_TRG1_CHECK_EN
        chk("trg1_nerr", de, 1);
        chk("trg1_nvalid", dv, 0);
`else
        model_accept();
        chk("trg1_nerr", de, 0);
        chk("trg1_nvalid", dv, 1);
`endif
        check_outputs("trg1");
        pad.trg1 = 1'b1;

        repeat (5) @(posedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xe1ap_host_rx.md
Name: xe1ap_host_rx

Overview:
- Host-side receiver for the XE-1AP analog pad protocol.
- Downstream consumer of the XE-1AP pad emulation stage.
- On a poll request it drives req low then high, captures the 12 nybbles the pad strobes out with trg2, and decodes them into active-high buttons and three 8-bit analog channels.
- Used for loopback verification of the pad stage and as the core-side reader for XHE-3-style attachments.

Parameters:
- CLKPERUSEC, 50: clk_sys cycles per microsecond (the microsecond tick divider).
- REQ_LOW_US, 4: microseconds req is held low per poll.
- TIMEOUT_US, 200: maximum microseconds between req release and the first trg2 fall, and between successive trg2 falls.
- SAMPLE_DLY_CLKS, 2: clk_sys cycles between detecting a trg2 fall and sampling data.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- poll  in  1  one-cycle start strobe
- trg1  in  1  pad trg1 (asynchronous)
- trg2  in  1  pad trg2; a falling edge means data is ready (asynchronous)
- data  in  4  pad data nybble (asynchronous)
- req  out  1  request line to the pad
- busy  out  1  high from accepted poll until DONE/ERR exit
- frame_valid  out  1  one-cycle pulse; decoded outputs updated
- frame_err  out  1  one-cycle pulse on timeout or check failure
- frame_raw  out  48  nybble k at bits [4k+3:4k], k=0 is first received
- buttons  out  12  active-high {A,B,C,D,E1,E2,Start,Select,A,B,A',B'}
- ch0  out  8  Y axis
- ch1  out  8  X axis
- ch2  out  8  throttle

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - req=1, busy=0, frame_valid=0, frame_err=0.
  - frame_raw=48'hFFFF_FFFF_FFFF, buttons=0, ch0=ch1=ch2=8'h00.
  - State IDLE; counters zeroed; synchronizers preset to 1.
- Input synchronizers: trg1, trg2 and data each pass through 2 flops. A falling edge is sync trg2 ==0 with the previous value ==1.
- Microsecond tick: 1-cycle pulse every CLKPERUSEC clocks. The divider restarts on each state entry.
- IDLE:
  - poll=1 leads to REQ_LOW, with req<=0, busy<=1, nybble index idx<=0.
  - poll while busy is ignored (not queued).
- REQ_LOW: after REQ_LOW_US ticks, req<=1 and go to WAIT_EDGE with the timeout counter cleared.
- WAIT_EDGE:
  - On a trg2 fall, go to SAMPLE (delay counter = SAMPLE_DLY_CLKS).
  - If the timeout counter reaches TIMEOUT_US ticks, go to ERR.
  - Edge and timeout in the same cycle: edge wins.
- SAMPLE:
  - After the delay, write sync data into nybble idx of a shadow register, then idx<=idx+1.
  - If idx was 11, go to DONE; otherwise return to WAIT_EDGE and clear the timeout counter.
  - trg2 falls arriving during SAMPLE are ignored.
- DONE (one cycle):
  - frame_raw<=shadow.
  - Decode, where n[k] is nybble k:
    - buttons[11:8]=~n0, buttons[7:4]=~n1, buttons[3:0]=~n10.
    - ch0={n2,n6}, ch1={n3,n7}, ch2={n4,n8}.
  - n5, n9 and n11 are captured raw only.
  - Pulse frame_valid, clear busy, go to IDLE.
- ERR (one cycle):
  - Pulse frame_err, req<=1, busy<=0, go to IDLE.
  - All decoded outputs and frame_raw keep their previous values.
- poll in the DONE/ERR cycle is ignored. It is accepted from the next cycle in IDLE.
- Fewer than 12 falls before timeout gives ERR. Extra falls after DONE are ignored in IDLE.
- A 3-bit-safe 4-bit idx never wraps; idx is held below 12.

Optional Feature:
- Macro XE1AP_RX_TRG1_CHECK_EN.
- Defined:
  - At each sample, sync trg1 must equal the expected phase: 0 for even idx, 1 for odd idx.
  - On a mismatch, go to ERR immediately.
- Undefined: trg1 is ignored; its synchronizer is removed.

Decomposition:
- Shared package xe1ap_pkg holds:
  - NYBBLES=12.
  - State enum {IDLE, REQ_LOW, WAIT_EDGE, SAMPLE, DONE, ERR}.
  - Nybble index constants (IDX_BTN0=0, IDX_BTN1=1, IDX_Y_HI=2 … IDX_BTN2=10).
  - A frame-decode function.
- One natural sub-module: xe1ap_usec_tick, the CLKPERUSEC divider with restart input and tick output.

Test Plan:
- Loopback with the pad stage: joystick_0=32'h10 (button 1), left analog=16'h4080, right analog=16'h0000, poll.
  - Require frame_valid within 500 µs, buttons[11]=1, buttons[3]=1, buttons[10]=0.
  - Require ch0/ch1 to match the pad's nybble encoding: ch1=8'h00 for x=8'h80, and ch0=8'hC0 for y=8'h40.
- No pad (trg2 held 1), poll.
  - Require req low for 4 µs, frame_err exactly TIMEOUT_US+REQ_LOW_US µs later, busy=0, and outputs unchanged.
- Pad stops after 7 nybbles: require frame_err, and frame_raw still holding the previous good frame.
- A second poll during busy: require exactly one req low pulse and one frame_valid.
- Assert reset_n mid-frame after nybble 5.
  - Require req=1, busy=0, and outputs at reset values in the same cycle.
  - A subsequent poll must complete normally.
- With XE1AP_RX_TRG1_CHECK_EN: force trg1=0 throughout. Require frame_err at the nybble-1 sample; without the macro the frame is valid.
